// File: rtl/tluh_pkg.sv
// rtl/tluh_pkg.sv - TL-UH shared widths and arithmetic atomic opcodes
package tluh_pkg;

  parameter int TL_DW = 32;

  localparam logic [2:0] OP_MIN  = 3'd1;
  localparam logic [2:0] OP_MAX  = 3'd2;
  localparam logic [2:0] OP_MINU = 3'd3;
  localparam logic [2:0] OP_MAXU = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;

endpackage

// File: rtl/tluh_atomic_seq.sv
// rtl/tluh_atomic_seq.sv - locked read-modify-write sequencer for TL-UH arithmetic atomics
// Reads the old word, runs it through the shared AU, writes the result back and returns the old word.
module tluh_atomic_seq
  import tluh_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = TL_DW,
  parameter int TimeoutCycles = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_data_i,
  input  logic [2:0]    req_op_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_err_i,
  output logic          lock_o,
  output logic          au_enable_o,
  output logic [DW-1:0] au_op1_o,
  output logic [DW-1:0] au_op2_o,
  output logic          au_cin_o,
  output logic [2:0]    au_operation_o,
  input  logic [DW-1:0] au_result_i,
  input  logic          au_cout_i
);

  localparam int CW = $clog2(TimeoutCycles);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, WR_WAIT, RESP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [2:0]    op_q;
  logic [DW-1:0] old_q;
  logic [DW-1:0] result_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic op_legal;
  logic timeout_hit;
  logic unused_cout;

  assign op_legal    = (req_op_i >= OP_MIN) && (req_op_i <= OP_ADD);
  assign timeout_hit = (cnt_q == CW'(TimeoutCycles - 1));
  assign unused_cout = au_cout_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    rsp_data_o     = '0;
    rsp_err_o      = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    lock_o         = 1'b0;
    au_enable_o    = 1'b0;
    au_op1_o       = '0;
    au_op2_o       = '0;
    au_cin_o       = 1'b0;
    au_operation_o = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = op_legal ? RD_REQ : RESP;
        end
      end
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        lock_o     = 1'b1;
        if (mem_gnt_i) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        lock_o = 1'b1;
        if (mem_rvalid_i) begin
          state_d = mem_err_i ? RESP : EXEC;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      EXEC: begin
        lock_o         = 1'b1;
        au_enable_o    = 1'b1;
        au_op1_o       = old_q;
        au_op2_o       = data_q;
        au_operation_o = op_q;
        state_d        = WR_REQ;
      end
      WR_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = result_q;
        lock_o      = 1'b1;
        if (mem_gnt_i) begin
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        lock_o = 1'b1;
        if (mem_rvalid_i || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = old_q;
        rsp_err_o   = err_q;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // old_q stays 0 unless a clean read lands, so failed reads answer with data 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= '0;
      old_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            data_q   <= req_data_i;
            op_q     <= req_op_i;
            old_q    <= '0;
            result_q <= '0;
            err_q    <= !op_legal;
          end
        end
        RD_REQ, WR_REQ: begin
          if (mem_gnt_i) begin
            cnt_q <= '0;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              err_q <= 1'b1;
            end else begin
              old_q <= mem_rdata_i;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EXEC: begin
          result_q <= au_result_i;
        end
        WR_WAIT: begin
          if (mem_rvalid_i) begin
            err_q <= mem_err_i;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tluh_atomic_seq.sv
// tb/tb_tluh_atomic_seq.sv - directed bench for tluh_atomic_seq
// Provides a word memory with programmable grant/response delays and a reference AU.
module tb_tluh_atomic_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [2:0]  req_op;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        lock, au_enable, au_cin, au_cout;
  logic [31:0] au_op1, au_op2, au_result;
  logic [2:0]  au_operation;

  always #5 clk = ~clk;

  tluh_atomic_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .lock_o(lock), .au_enable_o(au_enable), .au_op1_o(au_op1), .au_op2_o(au_op2),
    .au_cin_o(au_cin), .au_operation_o(au_operation), .au_result_i(au_result), .au_cout_i(au_cout)
  );

  always_comb begin
    au_result = '0;
    case (au_operation)
      3'd1: au_result = ($signed(au_op1) < $signed(au_op2)) ? au_op1 : au_op2;
      3'd2: au_result = ($signed(au_op1) > $signed(au_op2)) ? au_op1 : au_op2;
      3'd3: au_result = (au_op1 < au_op2) ? au_op1 : au_op2;
      3'd4: au_result = (au_op1 > au_op2) ? au_op1 : au_op2;
      3'd5: au_result = au_op1 + au_op2;
      default: au_result = '0;
    endcase
  end
  assign au_cout = 1'b0;
  assign mem_err = 1'b0;

  logic [31:0] mem [0:255];
  int          gnt_dly, rv_dly;
  logic        rv_en;
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic        pend;
  logic [7:0]  pend_addr;
  int          rv_cnt, req_wait;
  int          wr_cnt = 0;
  logic [31:0] last_wdata, last_waddr;
  int          cyc = 0;

  assign mem_gnt    = mem_req && (req_wait >= gnt_dly);
  assign mem_rvalid = pend && (rv_cnt == 0) && rv_en;
  assign mem_rdata  = pend ? mem[pend_addr] : 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      rv_cnt   <= 0;
      req_wait <= 0;
    end else begin
      if (pl_we) mem[pl_addr] <= pl_data;
      if (pend) begin
        if (mem_rvalid || rsp_valid) pend <= 1'b0;
        else if (rv_cnt != 0) rv_cnt <= rv_cnt - 1;
      end
      if (mem_req && mem_gnt) begin
        pend      <= 1'b1;
        pend_addr <= mem_addr[7:0];
        rv_cnt    <= rv_dly;
        req_wait  <= 0;
        if (mem_we) begin
          mem[mem_addr[7:0]] <= mem_wdata;
          wr_cnt     <= wr_cnt + 1;
          last_wdata <= mem_wdata;
          last_waddr <= mem_addr;
        end
      end else if (mem_req) begin
        req_wait <= req_wait + 1;
      end
    end
  end

  logic [31:0] exp_addr, exp_wdata;
  int req_cycles = 0, lock_cycles = 0, addr_bad = 0, wdata_bad = 0, lock_gap = 0;
  logic prev_lock = 1'b0;

  always @(negedge clk) begin
    if (mem_req) req_cycles <= req_cycles + 1;
    if (lock) lock_cycles <= lock_cycles + 1;
    if (mem_req && mem_addr !== exp_addr) addr_bad <= addr_bad + 1;
    if (mem_req && mem_we && mem_wdata !== exp_wdata) wdata_bad <= wdata_bad + 1;
    if (prev_lock && !lock && !rsp_valid && rst_n) lock_gap <= lock_gap + 1;
    prev_lock <= lock;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic do_atomic(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input int stall, output logic [31:0] rdata, output logic err,
                           output int lat, output int unstable);
    int n;
    int t0;
    unstable = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    lat   = cyc - t0;
    rdata = rsp_data;
    err   = rsp_err;
    if (!rsp_valid) check("rsp_wait_expired", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== rdata || rsp_err !== err) unstable++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [2:0]  op_tab  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [31:0] res_tab [5] = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h0};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, unst;
    int          s_req, s_lock, s_wr, s_addr, s_wd, s_gap;

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; gnt_dly = 0; rv_dly = 0; rv_en = 1'b1;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0; exp_addr = '0; exp_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_lock",      32'(lock),      32'd0);
    check("rst_au_enable", 32'(au_enable), 32'd0);
    rst_n = 1'b1;

    preload(8'h10, 32'h5);
    exp_addr = 32'h10; exp_wdata = 32'h8;
    do_atomic(3'd5, 32'h10, 32'h3, 0, rd, er, lat, unst);
    check("add_rdata",  rd, 32'h5);
    check("add_err",    32'(er), 32'd0);
    check("add_lat",    32'(lat), 32'd6);
    check("add_wdata",  last_wdata, 32'h8);
    check("add_waddr",  last_waddr, 32'h10);
    check("add_memval", mem[8'h10], 32'h8);

    for (int i = 0; i < 5; i++) begin
      preload(8'h20, 32'hFFFF_FFFF);
      exp_addr = 32'h20; exp_wdata = res_tab[i];
      s_wr = wr_cnt;
      do_atomic(op_tab[i], 32'h20, 32'h1, 0, rd, er, lat, unst);
      check($sformatf("op%0d_rdata", op_tab[i]), rd, 32'hFFFF_FFFF);
      check($sformatf("op%0d_wdata", op_tab[i]), last_wdata, res_tab[i]);
      check($sformatf("op%0d_wrcnt", op_tab[i]), 32'(wr_cnt - s_wr), 32'd1);
    end

    s_req = req_cycles; s_lock = lock_cycles; s_wr = wr_cnt;
    do_atomic(3'd6, 32'h20, 32'h1, 0, rd, er, lat, unst);
    check("illop_err",   32'(er), 32'd1);
    check("illop_data",  rd, 32'h0);
    check("illop_memreq", 32'(req_cycles - s_req), 32'd0);
    check("illop_lock",  32'(lock_cycles - s_lock), 32'd0);
    check("illop_wr",    32'(wr_cnt - s_wr), 32'd0);

    preload(8'h30, 32'h8000_0000);
    gnt_dly = 3; rv_dly = 5;
    exp_addr = 32'h30; exp_wdata = 32'h1234;
    s_lock = lock_cycles; s_addr = addr_bad; s_wd = wdata_bad; s_gap = lock_gap;
    do_atomic(3'd3, 32'h30, 32'h1234, 0, rd, er, lat, unst);
    check("slow_rdata",  rd, 32'h8000_0000);
    check("slow_err",    32'(er), 32'd0);
    check("slow_wdata",  last_wdata, 32'h1234);
    check("slow_lat",    32'(lat), 32'd22);
    check("slow_lockcyc", 32'(lock_cycles - s_lock), 32'd21);
    check("slow_lockgap", 32'(lock_gap - s_gap), 32'd0);
    check("slow_addr",   32'(addr_bad - s_addr), 32'd0);
    check("slow_wdhold", 32'(wdata_bad - s_wd), 32'd0);
    gnt_dly = 0; rv_dly = 0;

    preload(8'h40, 32'h77);
    exp_addr = 32'h40;
    rv_en = 1'b0; s_wr = wr_cnt;
    do_atomic(3'd5, 32'h40, 32'h1, 0, rd, er, lat, unst);
    check("tmo_err",  32'(er), 32'd1);
    check("tmo_data", rd, 32'h0);
    check("tmo_lat",  32'(lat), 32'd66);
    check("tmo_wr",   32'(wr_cnt - s_wr), 32'd0);
    rv_en = 1'b1;

    preload(8'h50, 32'h9);
    exp_addr = 32'h50; exp_wdata = 32'h9;
    do_atomic(3'd4, 32'h50, 32'h3, 4, rd, er, lat, unst);
    check("stall_rdata",  rd, 32'h9);
    check("stall_stable", 32'(unst), 32'd0);

    preload(8'h60, 32'h100);
    gnt_dly = 3;
    exp_addr = 32'h60; exp_wdata = 32'h101;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h60; req_data = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 50 && !(mem_req && mem_we); n++) @(negedge clk);
    check("rstwr_reached", 32'(mem_req && mem_we), 32'd1);
    s_wr = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("rstwr_req_ready", 32'(req_ready), 32'd1);
    check("rstwr_mem_req",   32'(mem_req), 32'd0);
    check("rstwr_lock",      32'(lock), 32'd0);
    check("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwr_mem_addr",  mem_addr, 32'h0);
    check("rstwr_wdata",     mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_dly = 0;
    check("rstwr_nowrite", 32'(wr_cnt - s_wr), 32'd0);
    check("rstwr_memkeep", mem[8'h60], 32'h100);
    do_atomic(3'd5, 32'h60, 32'h1, 0, rd, er, lat, unst);
    check("post_rdata", rd, 32'h100);
    check("post_err",   32'(er), 32'd0);
    check("post_wdata", last_wdata, 32'h101);
    check("post_lat",   32'(lat), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tluh_atomic_seq.md
Name: tluh_atomic_seq

Overview:
- Sequencer that executes one TL-UH arithmetic atomic (MIN/MAX/MINU/MAXU/ADD) as a locked read-modify-write.
- Sits between the TL-UH device-side request decode and a single-port word memory.
- Drives the shared arithmetic unit through explicit AU ports and returns the pre-modification (old) memory value to the requester.
- One atomic in flight at a time; the memory lock is held across the read and write.

Parameters:
- AW, 32, address width.
- DW, tluh_pkg::TL_DW (32), data and operand width.
- TimeoutCycles, 64, maximum cycles to wait for mem_rvalid_i before aborting; must be ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  atomic request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  AW  word address
- req_data_i  in  DW  operand (op2)
- req_op_i  in  3  tluh_pkg code: 1 MIN, 2 MAX, 3 MINU, 4 MAXU, 5 ADD
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  DW  old memory value
- rsp_err_o  out  1  illegal op, memory error or timeout
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  write data
- mem_gnt_i  in  1  request granted
- mem_rvalid_i  in  1  read data / write ack valid
- mem_rdata_i  in  DW  read data
- mem_err_i  in  1  error, qualified by mem_rvalid_i
- lock_o  out  1  memory locked against other masters
- au_enable_o  out  1  AU enable
- au_op1_o  out  DW  AU operand 1 (old value)
- au_op2_o  out  DW  AU operand 2 (req_data)
- au_cin_o  out  1  AU carry in, constant 0
- au_operation_o  out  3  AU operation code
- au_result_i  in  DW  AU result
- au_cout_i  in  1  AU carry out; ignored, no overflow reporting

Behaviour:
- Reset (async, rst_ni=0):
  - State → IDLE.
  - All outputs 0, except req_ready_o=1.
  - Captured registers and timeout counter cleared.
  - Reset mid-operation abandons the transaction with no write issued.
- States: IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, WR_WAIT, RESP.
- IDLE:
  - req_ready_o=1 only in this state.
  - On handshake, capture addr, data and op.
  - Legal op (1..5) → RD_REQ.
  - Illegal op (0, 6, 7) → RESP with rsp_err_o=1, rsp_data_o=0, no memory access.
- RD_REQ:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=addr_q, lock_o=1.
  - Hold all request signals until mem_gnt_i, then → RD_WAIT.
- RD_WAIT:
  - lock_o=1; timeout counter increments each cycle.
  - On mem_rvalid_i: capture old_q=mem_rdata_i.
  - If mem_err_i → RESP with err=1.
  - Else → EXEC.
  - Counter reaching TimeoutCycles without rvalid → RESP with err=1, rsp_data_o=0.
- EXEC (exactly 1 cycle):
  - au_enable_o=1, au_op1_o=old_q, au_op2_o=data_q, au_operation_o=op_q, au_cin_o=0.
  - Register result_q=au_result_i → WR_REQ.
  - AU outputs are 0 in all other states.
- WR_REQ:
  - mem_req_o=1, mem_we_o=1, mem_wdata_o=result_q, lock_o=1.
  - Hold until mem_gnt_i → WR_WAIT.
- WR_WAIT:
  - lock_o=1 until mem_rvalid_i, then → RESP.
  - err = mem_err_i.
  - Same timeout rule as RD_WAIT; counter cleared on entry to each wait state.
- RESP:
  - rsp_valid_o=1; rsp_data_o=old_q (0 for illegal op or read error).
  - Outputs held stable until rsp_ready_i, then → IDLE.
  - lock_o=0.
- Timing with zero-wait memory (gnt in the request cycle, rvalid the next cycle): request accepted in cycle 0, rsp_valid_o high in cycle 6.
- ADD wraps modulo 2^DW.
- MIN/MAX compare two's-complement; MINU/MAXU compare unsigned.
- mem_rvalid_i outside RD_WAIT/WR_WAIT is ignored.
- Write-ack error still returns old_q with err=1; memory contents are then undefined.
- A new request is not accepted in the same cycle as the rsp_ready_i handshake; req_ready_o rises in the following IDLE cycle.

Test Plan:
- Zero-wait memory, mem[0x10]=0x0000_0005, ADD operand 0x3 → write 0x8 to 0x10; rsp_data=0x5, err=0; rsp_valid high in cycle 6.
- mem=0xFFFF_FFFF, operand 0x1: MIN → write 0xFFFF_FFFF; MINU → write 0x1; MAXU → write 0xFFFF_FFFF; ADD → write 0x0 (wrap). rsp_data=0xFFFF_FFFF in every case.
- req_op=6 → rsp_valid with err=1, data=0; mem_req_o stays 0 and lock_o never asserts.
- gnt delayed 3 cycles and rvalid delayed 5 cycles → address and data held stable throughout; lock_o high continuously from RD_REQ through WR_WAIT; result correct.
- No rvalid in RD_WAIT → err response exactly TimeoutCycles cycles after RD_WAIT entry; no write issued.
- rsp_ready_i held low 4 cycles → rsp outputs stable. Separately, assert rst_ni=0 during WR_REQ → all outputs 0 and req_ready_o=1 immediately; next request completes normally.
